// File: rtl/inst_rr_arbiter.sv
// Round-robin arbiter: one owner at a time, grant held until done, priority rotates after each grant.
// Optional forced release after MAX_HOLD cycles when the ARB_TIMEOUT_EN macro is defined.
module inst_rr_arbiter #(
    parameter  int NUM_REQ  = 5,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("inst_rr_arbiter: NUM_REQ out of range 2..8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("inst_rr_arbiter: MAX_HOLD out of range 2..255");
    end

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDW-1:0]     last_id_q, last_id_d;
    logic               timeout_q, timeout_d;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     scan_idx;
    logic               release_now;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    // Scan starts just after the last winner, so the previous owner is seen last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDW'((int'(last_id_q) + k) % NUM_REQ);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        last_id_d     = last_id_q;
        timeout_d     = 1'b0;
        release_now   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d = '0;
`endif
                if (win_found) begin
                    grant_d         = '0;
                    grant_d[win_id] = 1'b1;
                    grant_id_d      = win_id;
                    grant_valid_d   = 1'b1;
                    last_id_d       = win_id;
                    state_d         = S_OWNED;
                end
            end
            S_OWNED: begin
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                if (done[grant_id_q]) begin
                    release_now = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    // Forced release; done wins when both occur together.
                    release_now = 1'b1;
                    timeout_d   = 1'b1;
`endif
                end
                if (release_now) begin
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            last_id_q     <= IDW'(NUM_REQ - 1);
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            last_id_q     <= last_id_d;
            timeout_q     <= timeout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_inst_rr_arbiter.sv
// Scoreboard bench for inst_rr_arbiter: each step pushes the expected post-edge outputs,
// then pops and compares them one time unit after the rising edge.
module tb_inst_rr_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [2:0]   grant_id;
    logic         grant_valid;
    logic         timeout;

    typedef struct {
        logic [N-1:0] grant;
        logic         timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    inst_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] dn, input logic [N-1:0] eg, input logic et);
        exp_t e;
        int   eid;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        exp_q.push_back('{grant: eg, timeout: et});
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        eid = 0;
        for (int i = 0; i < N; i++) if (e.grant[i]) eid = i;
        check_eq({tag, ".grant"}, 32'(grant), 32'(e.grant));
        check_eq({tag, ".valid"}, 32'(grant_valid), 32'(|e.grant));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(e.timeout));
        check_eq({tag, ".inv"}, 32'((grant_valid == |grant) && ($countones(grant) <= 1)), 32'd1);
        if (|e.grant) check_eq({tag, ".id"}, 32'(grant_id), 32'(eid));
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = '0;

        step("rst0", 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        step("rst1", 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        check_eq("rst.id", 32'(grant_id), 32'd0);
        step("idle", 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        // Single request, then release.
        step("single.g", 1'b0, 5'b00100, 5'b00000, 5'b00100, 1'b0);
        step("single.r", 1'b0, 5'b00000, 5'b00100, 5'b00000, 1'b0);
        step("single.i", 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        // Rotation from reset: 0,1,2,3,4,0 with one empty cycle between owners.
        step("rot.rst", 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] oh;
            oh = 5'b00001 << (k % N);
            step($sformatf("rot%0d.g", k), 1'b0, 5'b11111, 5'b00000, oh, 1'b0);
            step($sformatf("rot%0d.r", k), 1'b0, 5'b11111, oh, 5'b00000, 1'b0);
        end

        // Only the previous owner (0) requests: re-granted.
        step("regrant.g", 1'b0, 5'b00001, 5'b00000, 5'b00001, 1'b0);
        step("regrant.r", 1'b0, 5'b00000, 5'b00001, 5'b00000, 1'b0);

        // Foreign done and dropped request do not release owner 1.
        step("hold.g",   1'b0, 5'b00010, 5'b00000, 5'b00010, 1'b0);
        step("hold.fd",  1'b0, 5'b00010, 5'b01000, 5'b00010, 1'b0);
        step("hold.drp", 1'b0, 5'b00000, 5'b00000, 5'b00010, 1'b0);
        step("hold.fd2", 1'b0, 5'b00000, 5'b10101, 5'b00010, 1'b0);
        step("hold.r",   1'b0, 5'b00000, 5'b00010, 5'b00000, 1'b0);

        // Reset while owner 3 holds, then full request grants owner 0.
        step("mid.g",   1'b0, 5'b01000, 5'b00000, 5'b01000, 1'b0);
        step("mid.h",   1'b0, 5'b01000, 5'b00000, 5'b01000, 1'b0);
        step("mid.rst", 1'b1, 5'b01000, 5'b00000, 5'b00000, 1'b0);
        check_eq("mid.id", 32'(grant_id), 32'd0);
        step("mid.g0",  1'b0, 5'b11111, 5'b00000, 5'b00001, 1'b0);
        step("mid.r0",  1'b0, 5'b00000, 5'b00001, 5'b00000, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Owner 0 never completes: four cycles of grant, then forced release.
        step("to.rst", 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        step("to.g",   1'b0, 5'b00001, 5'b00000, 5'b00001, 1'b0);
        for (int k = 0; k < 3; k++)
            step($sformatf("to.h%0d", k), 1'b0, 5'b00001, 5'b00000, 5'b00001, 1'b0);
        step("to.rel", 1'b0, 5'b00011, 5'b00000, 5'b00000, 1'b1);
        step("to.g1",  1'b0, 5'b00011, 5'b00000, 5'b00010, 1'b0);
        // done coinciding with the timeout edge is an ordinary release.
        for (int k = 0; k < 3; k++)
            step($sformatf("to.d%0d", k), 1'b0, 5'b00000, 5'b00000, 5'b00010, 1'b0);
        step("to.both", 1'b0, 5'b00000, 5'b00010, 5'b00000, 1'b0);
`else
        // Without the timeout, a grant is held indefinitely.
        step("nto.rst", 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        step("nto.g",   1'b0, 5'b00001, 5'b00000, 5'b00001, 1'b0);
        for (int k = 0; k < 100; k++)
            step($sformatf("nto.h%0d", k), 1'b0, 5'b00011, 5'b00000, 5'b00001, 1'b0);
        step("nto.r",   1'b0, 5'b00000, 5'b00001, 5'b00000, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_rr_arbiter.md
# inst_rr_arbiter

Round-robin arbiter that shares one downstream resource among the sibling instances of a hierarchy root. Each child instance raises a request. The arbiter grants exactly one child at a time, holds the grant until that child signals completion, and then rotates priority. It sits at the root level, between the child instances and the shared resource they contend for.

## Interface
- `NUM_REQ`, 5, number of requesters; legal range 2..8.
- `MAX_HOLD`, 16, cycles a grant may be held before forced release; only used with `ARB_TIMEOUT_EN`; legal range 2..255.
- `IDW`, `$clog2(NUM_REQ)`, width of `grant_id`; derived, not overridden.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level; bit i belongs to requester i.
- `done`  in  NUM_REQ  per-requester release pulse; only the bit of the current owner is honoured.
- `grant`  out  NUM_REQ  one-hot grant, or all zeros; registered.
- `grant_id`  out  IDW  index of the current owner; valid only while `grant_valid` is high.
- `grant_valid`  out  1  high when `grant` is nonzero.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- **States.** IDLE and OWNED.
- **IDLE.**
  - If `req` is nonzero, select the first set bit scanning `last_id+1, last_id+2, …` with wrap modulo `NUM_REQ`.
  - Register `grant`, `grant_id` and `grant_valid`, load `last_id` with the winner, and go to OWNED.
  - If `req` is zero, stay in IDLE with the outputs low.
- **OWNED.**
  - Outputs hold.
  - If `done[grant_id]` is high, clear `grant`/`grant_valid` and go to IDLE.
- **Ignored inputs.**
  - `done` bits of non-owners have no effect.
  - A request dropped by the owner while it is in OWNED does not release the grant; only `done` (or a timeout) releases it.
- **Pointer.**
  - `last_id` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
  - `last_id` changes only when a grant is issued.
- **Single requester.** If only the previous owner is requesting, it is re-granted. Round-robin skips to it after a full scan.
- **Invariant.** `grant` is never multi-hot; `grant_valid == |grant`.
- **Unused inputs.** `req`/`done` bits at index ≥ `NUM_REQ` do not exist. Inputs are exactly `NUM_REQ` wide.

## Timing
- **Reset values.** All outputs are 0 (`grant=0`, `grant_id=0`, `grant_valid=0`, `timeout=0`), state is IDLE, `last_id=NUM_REQ-1`.
- **Reset mid-grant.** Outputs clear on the same edge `rst` is sampled high. No `timeout` pulse is generated.
- **Grant latency.** `req` sampled in IDLE at edge t gives `grant` high after edge t, i.e. visible in cycle t+1.
- **Release latency.** `done[owner]` sampled at edge t gives `grant` low in cycle t+1.
- **Arbitration after release.**
  - The arbiter is in IDLE during cycle t+1 and arbitrates there.
  - The next grant is visible in cycle t+2.
  - This gives a guaranteed minimum of one idle cycle between owners.
- **Simultaneous events.**
  - `done[owner]` together with new requests in the same cycle: release first; the new requests are arbitrated in the following IDLE cycle.
  - `done` and a timeout in the same cycle: treated as a normal `done`, and `timeout` stays 0.
- **Back-to-back.** With all requests held, the sustained rate is one grant per (hold time + 1) cycles.

## Configuration
- **Macro:** `ARB_TIMEOUT_EN`.
- **Defined.**
  - An 8-bit hold counter clears on entry to OWNED and increments each OWNED cycle.
  - When the counter reaches `MAX_HOLD-1` without `done[owner]`, the grant is released on that edge exactly as for `done`, and `timeout` pulses high for the one cycle in which `grant` is low.
  - `last_id` is unchanged by a timeout, so the timed-out owner gets the lowest priority next.
- **Undefined.**
  - No counter is built and `timeout` is tied to 0.
  - A grant is held indefinitely until `done`.

## Test plan
- **Reset then single request.** Reset, then `req=5'b00100`: `grant=00100`, `grant_id=2`, `grant_valid=1` in the cycle after `req`. Pulse `done[2]`: `grant=0` in the next cycle.
- **Rotation.** `req=5'b11111` held, each owner pulses `done` one cycle after its grant: the grant order is 0,1,2,3,4,0. There is exactly one zero-grant cycle between consecutive owners.
- **Foreign done / dropped req.**
  - Owner 1 granted. `done=5'b01000` is asserted, then `req[1]` is dropped.
  - `grant` stays `00010` throughout, until `done[1]` is asserted.
- **Reset mid-grant.** `rst` is asserted while owner 3 holds.
  - Outputs are all 0 after that edge and `timeout=0`.
  - After reset, `req=11111` grants owner 0.
- **Timeout (with `ARB_TIMEOUT_EN`, `MAX_HOLD=4`).**
  - Owner 0 is granted and never asserts `done`.
  - `grant` is high for exactly 4 cycles, then low with `timeout=1` for one cycle.
  - With `req=00011`, the next grant goes to owner 1.
- **Timeout disabled.** Same stimulus without the macro: `grant` stays `00001` for 100 cycles and `timeout` is always 0.
